// File: rtl/mii_rx_frame_assembler.sv
// MII receive frame assembler.
// Watches the 64-bit data / 8-bit control MII stream. It collects every byte
// from START through TERMINATE into a flat buffer and then presents the whole
// frame with a one-cycle valid pulse. Aborted frames and oversized frames are
// flagged with their own pulses and are never presented as valid.
module mii_rx_frame_assembler #(
  parameter int         DATA_WIDTH  = 64,
  parameter int         CTRL_WIDTH  = 8,
  parameter int         FRAME_BYTES = 1536,
  parameter logic [7:0] IDLE_CODE   = 8'h07,
  parameter logic [7:0] START_CODE  = 8'hFB,
  parameter logic [7:0] TERM_CODE   = 8'hFD
) (
  input  logic                     clk,
  input  logic                     i_rst_n,
  input  logic [DATA_WIDTH-1:0]    i_rx_data,
  input  logic [CTRL_WIDTH-1:0]    i_rx_ctrl,
  output logic [FRAME_BYTES*8-1:0] o_frame_data,
  output logic [15:0]              o_frame_len,
  output logic                     o_frame_valid,
  output logic                     o_frame_error,
  output logic                     o_overflow,
  output logic                     o_busy,
  output logic [31:0]              o_frame_count
);

  localparam int FRAME_WORDS = FRAME_BYTES / CTRL_WIDTH;
  localparam int PTR_W       = $clog2(FRAME_WORDS) + 1;
  localparam int IDX_W       = PTR_W - 1;
  localparam int LANE_W      = $clog2(CTRL_WIDTH);

  // The byte-lane layout requires 8-bit lanes, whole buffer words and
  // distinct control codes.
  if ((FRAME_BYTES % 8) != 0 || DATA_WIDTH != 8 * CTRL_WIDTH ||
      IDLE_CODE == START_CODE || IDLE_CODE == TERM_CODE ||
      START_CODE == TERM_CODE) begin : g_param_check
    $error("mii_rx_frame_assembler: inconsistent parameters");
  end

  typedef enum logic [1:0] {ST_IDLE, ST_COLLECT, ST_DISCARD} state_t;

  state_t               r_state;
  logic [PTR_W-1:0]     r_ptr;
  logic [DATA_WIDTH-1:0] r_buf [FRAME_WORDS];
  logic [15:0]          r_len;
  logic                 r_valid;
  logic                 r_err;
  logic                 r_ovf;
  logic                 r_busy;
  logic [31:0]          r_count;

  logic                  w_start;
  logic                  w_term_found;
  logic [LANE_W-1:0]     w_term_lane;
  logic                  w_bad_ctrl;
  logic [DATA_WIDTH-1:0] w_term_mask;
  logic                  w_full;
  logic [IDX_W-1:0]      w_ptr_idx;
  logic [15:0]           w_len;

  state_t                w_nstate;
  logic                  w_load;
  logic                  w_store;
  logic [DATA_WIDTH-1:0] w_store_word;
  logic                  w_valid_d;
  logic                  w_err_d;
  logic                  w_ovf_d;

  assign w_start   = i_rx_ctrl[0] && (i_rx_data[7:0] == START_CODE);
  assign w_full    = (r_ptr == PTR_W'(FRAME_WORDS));
  assign w_ptr_idx = r_ptr[IDX_W-1:0];
  assign w_len     = 16'(r_ptr) * 16'(CTRL_WIDTH) + 16'(w_term_lane) + 16'd1;

  // Locate the lowest lane that carries a TERMINATE control character.
  always_comb begin
    w_term_found = 1'b0;
    w_term_lane  = '0;
    for (int l = CTRL_WIDTH - 1; l >= 0; l--) begin
      if (i_rx_ctrl[l] && (i_rx_data[8*l +: 8] == TERM_CODE)) begin
        w_term_found = 1'b1;
        w_term_lane  = LANE_W'(l);
      end
    end
  end

  // Flag control characters ahead of TERMINATE and build the keep-mask for lanes 0..L.
  always_comb begin
    w_bad_ctrl  = 1'b0;
    w_term_mask = '0;
    for (int l = 0; l < CTRL_WIDTH; l++) begin
      if (i_rx_ctrl[l] && (i_rx_data[8*l +: 8] != TERM_CODE) &&
          (!w_term_found || (l < int'(w_term_lane))))
        w_bad_ctrl = 1'b1;
      if (w_term_found && (l <= int'(w_term_lane)))
        w_term_mask[8*l +: 8] = 8'hFF;
    end
  end

  // Decide next state, buffer action and which status pulse to raise.
  always_comb begin
    w_nstate     = r_state;
    w_load       = 1'b0;
    w_store      = 1'b0;
    w_store_word = i_rx_data;
    w_valid_d    = 1'b0;
    w_err_d      = 1'b0;
    w_ovf_d      = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (w_start) begin
          if (w_term_found) begin
            // START and TERMINATE in one word is an aborted frame.
            w_err_d = 1'b1;
          end else begin
            w_load   = 1'b1;
            w_nstate = ST_COLLECT;
          end
        end
      end
      ST_COLLECT: begin
        if (w_full) begin
          w_ovf_d  = 1'b1;
          w_nstate = w_term_found ? ST_IDLE : ST_DISCARD;
        end else if (w_bad_ctrl) begin
          w_err_d = 1'b1;
          if (w_start && !w_term_found) w_load = 1'b1;
          else                          w_nstate = ST_IDLE;
        end else if (w_term_found) begin
          w_store      = 1'b1;
          w_store_word = i_rx_data & w_term_mask;
          w_valid_d    = 1'b1;
          w_nstate     = ST_IDLE;
        end else begin
          w_store = 1'b1;
        end
      end
      ST_DISCARD: begin
        if (w_start && !w_term_found) begin
          w_load   = 1'b1;
          w_nstate = ST_COLLECT;
        end else if (w_term_found) begin
          w_nstate = ST_IDLE;
        end
      end
      default: w_nstate = ST_IDLE;
    endcase
  end

  // Frame state machine, word pointer, registered status outputs.
  always_ff @(posedge clk) begin
    if (!i_rst_n) begin
      r_state <= ST_IDLE;
      r_ptr   <= '0;
      r_len   <= '0;
      r_valid <= 1'b0;
      r_err   <= 1'b0;
      r_ovf   <= 1'b0;
      r_busy  <= 1'b0;
      r_count <= '0;
    end else begin
      r_state <= w_nstate;
      r_busy  <= (w_nstate != ST_IDLE);
      r_valid <= w_valid_d;
      r_err   <= w_err_d;
      r_ovf   <= w_ovf_d;
      if (w_load)
        r_ptr <= PTR_W'(1);
      else if (w_store && !w_valid_d)
        r_ptr <= r_ptr + PTR_W'(1);
      if (w_valid_d) begin
        r_len   <= w_len;
        r_count <= r_count + 32'd1;
      end
    end
  end

  // Frame buffer: cleared on START with the START word at index 0, then filled word by word.
  always_ff @(posedge clk) begin
    if (!i_rst_n) begin
      for (int i = 0; i < FRAME_WORDS; i++) r_buf[i] <= '0;
    end else if (w_load) begin
      for (int i = 0; i < FRAME_WORDS; i++) r_buf[i] <= '0;
      r_buf[0] <= i_rx_data;
    end else if (w_store) begin
      r_buf[w_ptr_idx] <= w_store_word;
    end
  end

  for (genvar g = 0; g < FRAME_WORDS; g++) begin : g_out
    assign o_frame_data[g*DATA_WIDTH +: DATA_WIDTH] = r_buf[g];
  end

  assign o_frame_len   = r_len;
  assign o_frame_valid = r_valid;
  assign o_frame_error = r_err;
  assign o_overflow    = r_ovf;
  assign o_busy        = r_busy;
  assign o_frame_count = r_count;

endmodule

// File: tb/tb_mii_rx_frame_assembler.sv
// Directed bench for the MII receive frame assembler.
module tb_mii_rx_frame_assembler;

  localparam int FRAME_BYTES = 1536;

  logic                     clk;
  logic                     i_rst_n;
  logic [63:0]              i_rx_data;
  logic [7:0]               i_rx_ctrl;
  logic [FRAME_BYTES*8-1:0] o_frame_data;
  logic [15:0]              o_frame_len;
  logic                     o_frame_valid;
  logic                     o_frame_error;
  logic                     o_overflow;
  logic                     o_busy;
  logic [31:0]              o_frame_count;

  mii_rx_frame_assembler #(.FRAME_BYTES(FRAME_BYTES)) dut (
    .clk           (clk),
    .i_rst_n       (i_rst_n),
    .i_rx_data     (i_rx_data),
    .i_rx_ctrl     (i_rx_ctrl),
    .o_frame_data  (o_frame_data),
    .o_frame_len   (o_frame_len),
    .o_frame_valid (o_frame_valid),
    .o_frame_error (o_frame_error),
    .o_overflow    (o_overflow),
    .o_busy        (o_busy),
    .o_frame_count (o_frame_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [63:0] data;
    logic [7:0]  ctrl;
    logic        v;
    logic        e;
    logic        o;
    logic        busy;
    logic [15:0] len;
  } vec_t;

  localparam logic [63:0] W_START = 64'hD5555555555555FB;
  localparam logic [63:0] W_TERM0 = 64'h07070707070707FD;
  localparam logic [63:0] W_IDLE  = 64'h0707070707070707;

  vec_t        tbl [18];
  logic [7:0]  mf [72];
  logic [7:0]  exp_bytes [FRAME_BYTES];
  int          n_checks;
  int          n_fail;
  logic [31:0] exp_cnt;
  logic [15:0] exp_len;

  function automatic vec_t mk(input logic [63:0] d, input logic [7:0] c,
                              input logic v, input logic e, input logic o,
                              input logic b, input logic [15:0] len);
    vec_t r;
    r.data = d; r.ctrl = c; r.v = v; r.e = e; r.o = o; r.busy = b; r.len = len;
    return r;
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic chk_frame(input string name);
    int bad;
    bad = -1;
    for (int k = FRAME_BYTES - 1; k >= 0; k--)
      if (o_frame_data[8*k +: 8] !== exp_bytes[k]) bad = k;
    n_checks++;
    if (bad >= 0) begin
      n_fail++;
      $display("FAIL %s: byte %0d got 0x%0h expected 0x%0h", name, bad,
               o_frame_data[8*bad +: 8], exp_bytes[bad]);
    end
  endtask

  task automatic step(input logic [63:0] d, input logic [7:0] c);
    i_rx_data = d;
    i_rx_ctrl = c;
    @(posedge clk);
    #1;
  endtask

  task automatic apply_vec(input vec_t r, input string tag);
    step(r.data, r.ctrl);
    if (r.v) begin
      exp_cnt = exp_cnt + 32'd1;
      exp_len = r.len;
    end
    chk({tag, ".valid"}, 64'(o_frame_valid), 64'(r.v));
    chk({tag, ".error"}, 64'(o_frame_error), 64'(r.e));
    chk({tag, ".ovf"},   64'(o_overflow),    64'(r.o));
    chk({tag, ".busy"},  64'(o_busy),        64'(r.busy));
    chk({tag, ".count"}, 64'(o_frame_count), 64'(exp_cnt));
    chk({tag, ".len"},   64'(o_frame_len),   64'(exp_len));
  endtask

  task automatic run_rows(input int first, input int last, input string tag);
    for (int i = first; i <= last; i++) apply_vec(tbl[i], $sformatf("%s.row%0d", tag, i));
  endtask

  task automatic clear_exp();
    for (int k = 0; k < FRAME_BYTES; k++) exp_bytes[k] = 8'h00;
  endtask

  task automatic load_min_exp();
    clear_exp();
    for (int k = 0; k < 72; k++) exp_bytes[k] = mf[k];
    exp_bytes[72] = 8'hFD;
  endtask

  initial begin
    logic [63:0] w;
    int ovf_at, ovf_hits, stray, idle_busy;
    n_checks = 0;
    n_fail   = 0;
    exp_cnt  = '0;
    exp_len  = '0;

    // Minimum frame model: preamble/SFD word, DA, SA, type/length, 46-byte payload, FCS.
    for (int k = 0; k < 8; k++) mf[k] = W_START[8*k +: 8];
    for (int k = 8; k < 14; k++) mf[k] = 8'hFF;
    mf[14] = 8'h12; mf[15] = 8'h34; mf[16] = 8'h56;
    mf[17] = 8'h78; mf[18] = 8'h9A; mf[19] = 8'hBC;
    mf[20] = 8'h00; mf[21] = 8'h2E;
    for (int k = 22; k < 68; k++) mf[k] = 8'(3 * k + 1);
    mf[68] = 8'hDE; mf[69] = 8'hAD; mf[70] = 8'hBE; mf[71] = 8'hEF;

    tbl[0] = mk(W_START, 8'h01, 0, 0, 0, 1, 16'd0);
    for (int wi = 1; wi <= 8; wi++) begin
      for (int b = 0; b < 8; b++) w[8*b +: 8] = mf[8*wi + b];
      tbl[wi] = mk(w, 8'h00, 0, 0, 0, 1, 16'd0);
    end
    tbl[9]  = mk(W_TERM0, 8'hFF, 1, 0, 0, 0, 16'd73);
    tbl[10] = mk(W_IDLE,  8'hFF, 0, 0, 0, 0, 16'd0);
    tbl[11] = mk(W_START, 8'h01, 0, 0, 0, 1, 16'd0);
    tbl[12] = mk(64'h1122334455667788, 8'h00, 0, 0, 0, 1, 16'd0);
    tbl[13] = mk(64'h11223344FE667788, 8'h08, 0, 1, 0, 0, 16'd0);
    tbl[14] = mk(W_IDLE,  8'hFF, 0, 0, 0, 0, 16'd0);
    tbl[15] = mk(64'h0123456789ABCDEF, 8'h00, 0, 0, 0, 0, 16'd0);
    tbl[16] = mk(64'h07070707070707FB << 8 | 64'h07, 8'h03, 0, 0, 0, 0, 16'd0);
    tbl[17] = mk(64'h070707070707FDFB, 8'hFF, 0, 1, 0, 0, 16'd0);

    // Reset state
    i_rst_n   = 1'b0;
    i_rx_data = '0;
    i_rx_ctrl = '0;
    step(W_IDLE, 8'hFF);
    step(W_IDLE, 8'hFF);
    chk("reset.valid", 64'(o_frame_valid), 64'd0);
    chk("reset.error", 64'(o_frame_error), 64'd0);
    chk("reset.ovf",   64'(o_overflow),    64'd0);
    chk("reset.busy",  64'(o_busy),        64'd0);
    chk("reset.count", 64'(o_frame_count), 64'd0);
    chk("reset.len",   64'(o_frame_len),   64'd0);
    clear_exp();
    chk_frame("reset.data");
    i_rst_n = 1'b1;

    // Minimum frame, then a mid-frame bad control character and IDLE-state corner words
    run_rows(0, 9, "min");
    load_min_exp();
    chk_frame("min.data");
    run_rows(10, 17, "err");

    // TERMINATE in lane 5: lanes 6-7 of that word must read 0
    apply_vec(mk(W_START, 8'h01, 0, 0, 0, 1, 16'd0), "t5.start");
    apply_vec(mk(64'h0807060504030201, 8'h00, 0, 0, 0, 1, 16'd0), "t5.d1");
    apply_vec(mk(64'h100F0E0D0C0B0A09, 8'h00, 0, 0, 0, 1, 16'd0), "t5.d2");
    apply_vec(mk(64'h0707FD1514131211, 8'hE0, 1, 0, 0, 0, 16'd30), "t5.term");
    clear_exp();
    for (int k = 0; k < 8; k++) exp_bytes[k] = W_START[8*k +: 8];
    for (int k = 8; k < 24; k++) exp_bytes[k] = 8'(k - 7);
    for (int k = 24; k < 29; k++) exp_bytes[k] = 8'(k - 24 + 8'h11);
    exp_bytes[29] = 8'hFD;
    chk_frame("t5.data");

    // START while collecting: error pulse, new frame restarts without stale bytes
    apply_vec(mk(W_START, 8'h01, 0, 0, 0, 1, 16'd0), "rs.startA");
    apply_vec(mk(64'hAAAAAAAAAAAAAAAA, 8'h00, 0, 0, 0, 1, 16'd0), "rs.dA");
    apply_vec(mk(64'h07060504030201FB, 8'h01, 0, 1, 0, 1, 16'd0), "rs.startB");
    apply_vec(mk(64'h2222222222222222, 8'h00, 0, 0, 0, 1, 16'd0), "rs.dB");
    apply_vec(mk(W_TERM0, 8'hFF, 1, 0, 0, 0, 16'd17), "rs.term");
    clear_exp();
    w = 64'h07060504030201FB;
    for (int k = 0; k < 8; k++) exp_bytes[k] = w[8*k +: 8];
    for (int k = 8; k < 16; k++) exp_bytes[k] = 8'h22;
    exp_bytes[16] = 8'hFD;
    chk_frame("rs.data");

    // Overflow: 200 data words with no TERMINATE
    apply_vec(mk(W_START, 8'h01, 0, 0, 0, 1, 16'd0), "of.start");
    ovf_at = 0; ovf_hits = 0; stray = 0; idle_busy = 0;
    for (int k = 1; k <= 200; k++) begin
      step({56'h0, 8'(k)}, 8'h00);
      if (o_overflow) begin
        ovf_hits++;
        ovf_at = k;
      end
      if (o_frame_valid || o_frame_error) stray++;
      if (!o_busy) idle_busy++;
    end
    chk("of.word",  64'(ovf_at),    64'd192);
    chk("of.hits",  64'(ovf_hits),  64'd1);
    chk("of.stray", 64'(stray),     64'd0);
    chk("of.busy",  64'(idle_busy), 64'd0);
    apply_vec(mk(W_TERM0, 8'hFF, 0, 0, 0, 0, 16'd0), "of.term");
    run_rows(0, 9, "of.next");
    load_min_exp();
    chk_frame("of.next.data");

    // Reset for one cycle mid-frame
    apply_vec(tbl[0], "rst.start");
    apply_vec(tbl[1], "rst.d1");
    i_rst_n = 1'b0;
    step(tbl[2].data, 8'h00);
    i_rst_n = 1'b1;
    exp_cnt = '0;
    exp_len = '0;
    chk("rst.valid", 64'(o_frame_valid), 64'd0);
    chk("rst.error", 64'(o_frame_error), 64'd0);
    chk("rst.ovf",   64'(o_overflow),    64'd0);
    chk("rst.busy",  64'(o_busy),        64'd0);
    chk("rst.count", 64'(o_frame_count), 64'd0);
    chk("rst.len",   64'(o_frame_len),   64'd0);
    clear_exp();
    chk_frame("rst.data");
    apply_vec(mk(tbl[3].data, 8'h00, 0, 0, 0, 0, 16'd0), "rst.tail");
    apply_vec(mk(W_TERM0, 8'hFF, 0, 0, 0, 0, 16'd0), "rst.term");
    run_rows(0, 9, "rst.next");
    load_min_exp();
    chk_frame("rst.next.data");
    chk("rst.final_count", 64'(o_frame_count), 64'd1);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/mii_rx_frame_assembler.md
Name: mii_rx_frame_assembler

Overview:
- Receive-side stage that sits directly upstream of the MAC frame checker.
- Watches the per-cycle 64-bit data / 8-bit control stream from the 1.6T MII.
- Detects START, collects every byte through TERMINATE into a flat frame buffer, then presents the whole frame with a one-cycle valid pulse.
- Aborted, malformed and oversized frames are flagged and never presented as valid.

Parameters:
- DATA_WIDTH, 64, MII data word width; 8 byte lanes, lane n = bits [8n+7:8n].
- CTRL_WIDTH, 8, one control flag per lane; 1 = lane carries a control character.
- FRAME_BYTES, 1536, frame buffer capacity in bytes; must be a multiple of 8.
- IDLE_CODE, 8'h07, idle control character.
- START_CODE, 8'hFB, start control character.
- TERM_CODE, 8'hFD, terminate control character.

Ports:
- clk  in  1  clock.
- i_rst_n  in  1  reset, synchronous, active-low.
- i_rx_data  in  DATA_WIDTH  MII data word, one per clock.
- i_rx_ctrl  in  CTRL_WIDTH  per-lane control flags.
- o_frame_data  out  FRAME_BYTES*8  assembled frame; byte k at bits [8k+7:8k].
- o_frame_len  out  16  byte count of the presented frame, START and TERM included.
- o_frame_valid  out  1  one-cycle pulse: o_frame_data / o_frame_len hold a complete good frame.
- o_frame_error  out  1  one-cycle pulse: frame aborted by an unexpected control character.
- o_overflow  out  1  one-cycle pulse: frame exceeded FRAME_BYTES.
- o_busy  out  1  high while a frame is being collected or discarded.
- o_frame_count  out  32  count of good frames presented; wraps at 2^32.

Behaviour:
- Clock and reset: one clock, clk. Reset is synchronous and active-low on i_rst_n.
- Reset values (i_rst_n low at a clk edge): all outputs 0, buffer cleared, state IDLE. Reset mid-frame discards the frame silently, with no error pulse.
- States: IDLE, COLLECT, DISCARD.
- IDLE:
  - A word with i_rx_ctrl[0]=1 and lane 0 = START_CODE starts a frame.
  - On start: clear the entire buffer to 0, write the word at word index 0, set word pointer to 1, go to COLLECT.
  - START in lanes 1-7 is ignored.
  - All other words are ignored.
- COLLECT, TERM found: the lowest lane L with ctrl=1 and byte=TERM_CODE is the terminate lane.
  - Write lanes 0..L of the word at pointer*8; lanes above L are not written and stay 0.
  - Length = pointer*8 + L + 1.
  - Next cycle: o_frame_valid=1, o_frame_len=length, o_frame_count+1. Return to IDLE.
- COLLECT, other control character: any lane below the terminate lane (or any lane if there is no TERM) with ctrl=1 and byte != TERM_CODE.
  - Next cycle: o_frame_error=1. Go to IDLE.
  - If that word has lane 0 = START, the error pulse is still raised and a new frame starts from this word (buffer cleared, pointer 1).
- COLLECT, all-data word: store it at pointer*8 and increment the pointer.
- Overflow: a word arriving when pointer == FRAME_BYTES/8 cannot be stored.
  - o_overflow=1 next cycle.
  - If that word holds TERM, go to IDLE; otherwise go to DISCARD.
- START and TERM in the same word (START lane 0, TERM lane 1..7): treated as an aborted frame. o_frame_error=1, no valid pulse, return to IDLE.
- DISCARD: nothing is written. A word with TERM goes to IDLE with no pulse. A START on lane 0 clears the buffer and enters COLLECT.
- o_busy = (state != IDLE), registered.
- Latency: the word carrying TERM is sampled at edge N; o_frame_valid is high during cycle N+1.
- Stability: o_frame_data and o_frame_len stay stable from the valid pulse until the next START clears the buffer. The consumer must latch during the valid cycle.
- Pulses: o_frame_valid, o_frame_error and o_overflow are mutually exclusive and each is high for exactly one cycle.
- Widths: pointer is clog2(FRAME_BYTES/8)+1 bits; length arithmetic is 16-bit unsigned.

Test Plan:
- Minimum frame: word0 = 64'hD5555555555555FB, ctrl 8'h01; 8 data words (DA FF..FF, SA 123456789ABC, length 16'h002E, 46-byte payload, 4-byte FCS, 72 bytes in total); then word 8'h07 x7 + FD in lane 0, ctrl 8'hFF.
  -> o_frame_valid one cycle later, o_frame_len=73, byte 72=FD, bytes 73+ = 0, o_frame_count=1.
- TERM in lane 5 of the last word -> o_frame_len = pointer*8+6; lanes 6-7 of that word read 0.
- Word with ctrl[3]=1, byte 8'hFE mid-frame -> o_frame_error pulse, no valid, count unchanged, o_busy falls.
- 200 data words with no TERM (FRAME_BYTES=1536) -> o_overflow pulses after word 192 fills. Subsequent TERM gives no valid. The next legal frame is presented normally.
- START word arrives while in COLLECT -> o_frame_error pulse. The new frame completes with o_frame_valid and a correct length; its buffer holds no stale bytes.
- i_rst_n low for one cycle mid-frame -> all outputs 0, no pulses. A later frame is assembled correctly and o_frame_count=1.
